cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the functional-unit result ports (adder, multiplier, load unit, spare) that compete to broadcast results.
- Arbitration is round-robin, at most one grant per cycle, with registered bus outputs.
- The selected result (RS tag plus data) is broadcast to the reservation stations, register file and instruction queue. The instruction queue uses it for write-back status.

---
 rtl/cdb_defs.sv | 13 +
 rtl/rr_pick.sv | 29 ++
 rtl/cdb_arbiter.sv | 99 +++++++++
 tb/tb_cdb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_defs.sv
// Shared result-bus definitions used by the arbiter, reservation stations and instruction queue.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package cdb_defs;

    localparam int   TAG_BITS  = 6;
    localparam int   DATA_BITS = 32;

    localparam logic TRUE      = 1'b1;
    localparam logic FALSE     = 1'b0;
    localparam logic CLEAR     = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: first eligible index at or after rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is used.
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int PTR_BITS = 2
) (
    input  logic [NUM_REQ-1:0]  eligible,
    input  logic [PTR_BITS-1:0] rr_ptr,
    output logic [PTR_BITS-1:0] winner,
    output logic                any_valid
);

    // Scan rr_ptr, rr_ptr+1, ... with wrap; the first hit wins.
    always_comb begin : pick
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!any_valid && eligible[idx]) begin
                any_valid = 1'b1;
                winner    = PTR_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus; one registered broadcast per cycle.
// Latency: one cycle from req to grant and bus output.
// Backpressure: cdb_hold blocks new grants and freezes the round-robin pointer.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_BITS  = cdb_defs::TAG_BITS,
    parameter int DATA_BITS = cdb_defs::DATA_BITS,
    parameter int PTR_BITS  = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*TAG_BITS-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic                           cdb_hold,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           cdb_valid,
    output logic [TAG_BITS-1:0]            cdb_tag,
    output logic [DATA_BITS-1:0]           cdb_data,
    output logic [PTR_BITS-1:0]            cdb_source,
    output logic [15:0]                    busy_cycles
);

    import cdb_defs::*;

    logic [NUM_REQ-1:0]   eligible;
    logic [PTR_BITS-1:0]  rr_ptr;
    logic [PTR_BITS-1:0]  rr_next;
    logic [PTR_BITS-1:0]  winner;
    logic                 any_valid;
    logic [TAG_BITS-1:0]  win_tag;
    logic [DATA_BITS-1:0] win_data;

    // A requester granted this cycle may still show req high; mask it so one
    // result is never broadcast twice.
    assign eligible = req & ~grant;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .PTR_BITS (PTR_BITS)
    ) u_pick (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Select the winner's tag/data slice from the flattened request buses.
    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_BITS'(i)) begin
                win_tag  = req_tag[i*TAG_BITS +: TAG_BITS];
                win_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        rr_next = winner + 1'b1;
        if (winner == PTR_BITS'(NUM_REQ - 1)) begin
            rr_next = '0;
        end
    end

    // Grant and bus registers; tag/data hold when idle since consumers gate on cdb_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant      <= '0;
            cdb_valid  <= CLEAR;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_source <= '0;
            rr_ptr     <= '0;
        end else if (!cdb_hold && any_valid) begin
            grant      <= NUM_REQ'(1) << winner;
            cdb_valid  <= TRUE;
            cdb_tag    <= win_tag;
            cdb_data   <= win_data;
            cdb_source <= winner;
            rr_ptr     <= rr_next;
        end else begin
            grant      <= '0;
            cdb_valid  <= FALSE;
        end
    end

    // Saturating count of edges that see a valid broadcast on the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_cycles <= '0;
        end else if (cdb_valid && (busy_cycles != 16'hFFFF)) begin
            busy_cycles <= busy_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for the common-data-bus round-robin arbiter.
// Latency: outputs checked 1 ns after the edge that registers them.
// Backpressure: cdb_hold driven directly by the stimulus tasks.
module tb_cdb_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   req;
    logic [23:0]  req_tag;
    logic [127:0] req_data;
    logic         cdb_hold;
    logic [3:0]   grant;
    logic         cdb_valid;
    logic [5:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_source;
    logic [15:0]  busy_cycles;

    logic [5:0]   tag_a  [4];
    logic [31:0]  data_a [4];

    int checks   = 0;
    int failures = 0;

    cdb_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_tag     (req_tag),
        .req_data    (req_data),
        .cdb_hold    (cdb_hold),
        .grant       (grant),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .cdb_source  (cdb_source),
        .busy_cycles (busy_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        req_tag  = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_tag[i*6 +: 6]    = tag_a[i];
            req_data[i*32 +: 32] = data_a[i];
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset    = 1'b1;
        req      = 4'b0000;
        cdb_hold = 1'b0;
        tick();
        tick();
        reset    = 1'b0;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        cdb_hold = 1'b0;
        req      = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tag_a[i]  = 6'(20 + i);
            data_a[i] = 32'hA000_0000 + 32'(i);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({grant, cdb_valid, cdb_tag, cdb_data, cdb_source, busy_cycles} !== 61'd0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: grant=%b valid=%b tag=%0d data=%h src=%0d busy=%0d, required all zero",
                         c, grant, cdb_valid, cdb_tag, cdb_data, cdb_source, busy_cycles);
            end
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({grant, cdb_valid, cdb_source, cdb_tag, cdb_data} !== {4'b0001, 1'b1, 2'd0, 6'd20, 32'hA000_0000}) begin
            failures++;
            $display("FAIL reset_first_grant: grant=%b valid=%b src=%0d tag=%0d data=%h, required 0001 1 0 20 a0000000",
                     grant, cdb_valid, cdb_source, cdb_tag, cdb_data);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({grant, cdb_valid, busy_cycles} !== {4'b0000, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL reset_idle_after: grant=%b valid=%b busy=%0d, required 0000 0 1", grant, cdb_valid, busy_cycles);
        end
    endtask

    task automatic test_single;
        do_reset();
        tag_a[2]  = 6'd5;
        data_a[2] = 32'hDEAD_BEEF;
        req       = 4'b0100;
        tick();
        checks++;
        if ({grant, cdb_valid, cdb_tag, cdb_data, cdb_source} !== {4'b0100, 1'b1, 6'd5, 32'hDEAD_BEEF, 2'd2}) begin
            failures++;
            $display("FAIL single_grant: grant=%b valid=%b tag=%0d data=%h src=%0d, required 0100 1 5 deadbeef 2",
                     grant, cdb_valid, cdb_tag, cdb_data, cdb_source);
        end
        req = 4'b0000;
        tick();
        checks++;
        if ({grant, cdb_valid} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL single_drop: grant=%b valid=%b, required 0000 0", grant, cdb_valid);
        end
        checks++;
        if ({cdb_tag, cdb_data} !== {6'd5, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL single_bus_hold: tag=%0d data=%h, required 5 deadbeef", cdb_tag, cdb_data);
        end
    endtask

    task automatic test_tag_zero;
        do_reset();
        tag_a[0]  = 6'd0;
        data_a[0] = 32'h0000_1234;
        req       = 4'b0001;
        tick();
        checks++;
        if ({grant, cdb_valid, cdb_tag, cdb_data} !== {4'b0001, 1'b1, 6'd0, 32'h0000_1234}) begin
            failures++;
            $display("FAIL tag_zero: grant=%b valid=%b tag=%0d data=%h, required 0001 1 0 00001234",
                     grant, cdb_valid, cdb_tag, cdb_data);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_grant [8];
        exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tag_a[i]  = 6'(10 + i);
            data_a[i] = 32'hC0DE_0000 + 32'(i);
        end
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            checks++;
            if ({grant, cdb_valid, cdb_source, cdb_tag} !== {exp_grant[c], 1'b1, 2'(c % 4), 6'(10 + c % 4)}) begin
                failures++;
                $display("FAIL rr_order cycle %0d: grant=%b valid=%b src=%0d tag=%0d, required %b 1 %0d %0d",
                         c, grant, cdb_valid, cdb_source, cdb_tag, exp_grant[c], c % 4, 10 + c % 4);
            end
        end
        checks++;
        if (busy_cycles !== 16'd7) begin
            failures++;
            $display("FAIL rr_busy_count: busy=%0d, required 7", busy_cycles);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_hold;
        do_reset();
        req      = 4'b0011;
        cdb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({grant, cdb_valid} !== {4'b0000, 1'b0}) begin
                failures++;
                $display("FAIL hold_blocked cycle %0d: grant=%b valid=%b, required 0000 0", c, grant, cdb_valid);
            end
        end
        cdb_hold = 1'b0;
        tick();
        checks++;
        if ({grant, cdb_source} !== {4'b0001, 2'd0}) begin
            failures++;
            $display("FAIL hold_release_first: grant=%b src=%0d, required 0001 0", grant, cdb_source);
        end
        req = 4'b0010;
        tick();
        checks++;
        if ({grant, cdb_source} !== {4'b0010, 2'd1}) begin
            failures++;
            $display("FAIL hold_release_second: grant=%b src=%0d, required 0010 1", grant, cdb_source);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_double_grant;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tag_a[i]  = 6'(30 + i);
            data_a[i] = 32'hB000_0000 + 32'(i);
        end
        req = 4'b1010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL dg_first: grant=%b, required 0010", grant);
        end
        tick();
        checks++;
        if ({grant, cdb_source, cdb_tag} !== {4'b1000, 2'd3, 6'd33}) begin
            failures++;
            $display("FAIL dg_masked: grant=%b src=%0d tag=%0d, required 1000 3 33", grant, cdb_source, cdb_tag);
        end
        req = 4'b0010;
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL dg_new_result: grant=%b, required 0010", grant);
        end
        tick();
        checks++;
        if ({grant, cdb_valid} !== {4'b0000, 1'b0}) begin
            failures++;
            $display("FAIL dg_sole_gap: grant=%b valid=%b, required 0000 0", grant, cdb_valid);
        end
        tick();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL dg_sole_regrant: grant=%b, required 0010", grant);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        tag_a[3]  = 6'd44;
        data_a[3] = 32'h5555_AAAA;
        req       = 4'b1000;
        tick();
        tick();
        tick();
        checks++;
        if ({grant, busy_cycles} !== {4'b1000, 16'd1}) begin
            failures++;
            $display("FAIL mid_setup: grant=%b busy=%0d, required 1000 1", grant, busy_cycles);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({grant, cdb_valid, cdb_tag, cdb_data, cdb_source, busy_cycles} !== 61'd0) begin
            failures++;
            $display("FAIL mid_reset: grant=%b valid=%b tag=%0d data=%h src=%0d busy=%0d, required all zero",
                     grant, cdb_valid, cdb_tag, cdb_data, cdb_source, busy_cycles);
        end
        reset = 1'b0;
        req   = 4'b1111;
        tick();
        checks++;
        if ({grant, cdb_source} !== {4'b0001, 2'd0}) begin
            failures++;
            $display("FAIL mid_restart: grant=%b src=%0d, required 0001 0", grant, cdb_source);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        reset    = 1'b1;
        req      = 4'b0000;
        cdb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tag_a[i]  = '0;
            data_a[i] = '0;
        end
        test_reset();
        test_single();
        test_tag_zero();
        test_round_robin();
        test_hold();
        test_double_grant();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
